// File: rtl/store_buffer.sv
// Word-granularity store buffer between the MEM stage and data memory.
// Queues stores, drains them in FIFO order, and serves loads by forwarding or DM read.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     req_ready,
  input  logic                     drain_hold,
  output logic                     load_valid,
  output logic [31:0]              load_data,
  output logic [31:0]              MemAddr,
  output logic [31:0]              MemWriteData,
  output logic                     MemWrite,
  output logic                     MemRead,
  input  logic [31:0]              MemReadData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;

  logic [AW-1:0] ent_addr [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic          accept;
  logic          push;
  logic          load;
  logic          hit;
  logic          miss;
  logic          drain;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;

  assign empty     = (count == CW'(0));
  assign full      = (count == CW'(DEPTH));
  assign req_ready = rst_n & ~full;
  assign accept    = req_valid & req_ready;
  assign push      = accept & req_write;
  assign load      = accept & ~req_write;
  assign miss      = load & ~hit;
  assign drain     = ~empty & ~drain_hold & ~miss;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (ent_addr[idx] == req_addr[31:2])) begin
        hit      = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end

  // DM port: a load miss owns the port, otherwise the head entry drains.
  always_comb begin
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    MemAddr      = '0;
    MemWriteData = '0;
    if (miss) begin
      MemRead = 1'b1;
      MemAddr = {req_addr[31:2], 2'b00};
    end else if (drain) begin
      MemWrite     = 1'b1;
      MemAddr      = {ent_addr[head], 2'b00};
      MemWriteData = ent_data[head];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)  tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      case ({push, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset; validity is tracked by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= req_addr[31:2];
      ent_data[tail] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_valid <= 1'b0;
      load_data  <= '0;
    end else begin
      load_valid <= load;
      if (load) load_data <= hit ? fwd_data : MemReadData;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a DM model and a load-result scoreboard.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        drain_hold;
  logic        load_valid;
  logic [31:0] load_data;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemReadData;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  logic [31:0] dm [256];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  assign MemReadData = dm[MemAddr[9:2]];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .drain_hold(drain_hold),
    .load_valid(load_valid), .load_data(load_data),
    .MemAddr(MemAddr), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemReadData(MemReadData),
    .count(count), .empty(empty), .full(full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  // One clock: DM captures writes at the edge; load results are scored after it.
  task automatic tick();
    logic        acc_load;
    logic        wr;
    logic [31:0] wa;
    logic [31:0] wd;
    #1;
    acc_load = req_valid && !req_write && req_ready;
    wr = MemWrite;
    wa = MemAddr;
    wd = MemWriteData;
    @(posedge clk);
    if (wr) dm[wa[9:2]] = wd;
    #1;
    if (acc_load) begin
      chk("load_valid", 32'(load_valid), 32'd1);
      if (exp_q.size() == 0) chk("load_sb_nonempty", 32'd0, 32'd1);
      else chk("load_data", load_data, exp_q.pop_front());
    end else begin
      chk("load_valid_idle", 32'(load_valid), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dm[i] = 32'h0;
    dm[8'h08] = 32'hDEADBEEF;
    rst_n = 1'b0;
    drain_hold = 1'b0;
    drive(1'b1, 1'b1, 32'h0, 32'h0);

    // Reset with a request pending
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_load_valid", 32'(load_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    tick();

    // Single store drains the following cycle
    drive(1'b1, 1'b1, 32'h0, 32'h01010101);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("drain1_memwrite", 32'(MemWrite), 32'd1);
    chk("drain1_addr", MemAddr, 32'h0);
    chk("drain1_data", MemWriteData, 32'h01010101);
    chk("drain1_count", 32'(count), 32'd1);
    tick();
    chk("drain1_count0", 32'(count), 32'd0);
    chk("drain1_dm", dm[0], 32'h01010101);

    // Forward from the youngest matching entry
    drain_hold = 1'b1;
    drive(1'b1, 1'b1, 32'h10, 32'hAAAA5555);
    tick();
    drive(1'b1, 1'b1, 32'h13, 32'h12345678);
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    exp_q.push_back(32'h12345678);
    #1;
    chk("fwd_memread", 32'(MemRead), 32'd0);
    chk("fwd_memwrite_held", 32'(MemWrite), 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drain_hold = 1'b0;
    #1;
    chk("fwd_drain_a_addr", MemAddr, 32'h10);
    chk("fwd_drain_a_data", MemWriteData, 32'hAAAA5555);
    tick();
    chk("fwd_drain_b_data", MemWriteData, 32'h12345678);
    tick();
    chk("fwd_count0", 32'(count), 32'd0);
    chk("fwd_dm", dm[4], 32'h12345678);

    // Load miss on an empty buffer
    drive(1'b1, 1'b0, 32'h22, 32'h0);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    chk("miss_memread", 32'(MemRead), 32'd1);
    chk("miss_addr", MemAddr, 32'h20);
    tick();

    // Load miss beats a pending drain
    drain_hold = 1'b1;
    drive(1'b1, 1'b1, 32'h30, 32'h00000055);
    tick();
    drain_hold = 1'b0;
    drive(1'b1, 1'b0, 32'h22, 32'h0);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    chk("prio_memread", 32'(MemRead), 32'd1);
    chk("prio_memwrite", 32'(MemWrite), 32'd0);
    chk("prio_count", 32'(count), 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("prio_drain_we", 32'(MemWrite), 32'd1);
    chk("prio_drain_addr", MemAddr, 32'h30);
    tick();
    chk("prio_count0", 32'(count), 32'd0);
    chk("prio_dm", dm[12], 32'h00000055);

    // Fill, hold a fifth store, then drain with wrap
    drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'(i * 4), 32'hD0000000 + 32'(i));
      tick();
    end
    chk("full_flag", 32'(full), 32'd1);
    chk("full_count", 32'(count), 32'd4);
    drive(1'b1, 1'b1, 32'h10, 32'hD0000004);
    #1;
    chk("full_ready", 32'(req_ready), 32'd0);
    tick();
    chk("full_still4", 32'(count), 32'd4);
    drain_hold = 1'b0;
    #1;
    chk("wrap_ready_first", 32'(req_ready), 32'd0);
    chk("wrap_d0_addr", MemAddr, 32'h0);
    tick();
    chk("wrap_ready_after_pop", 32'(req_ready), 32'd1);
    chk("wrap_d1_addr", MemAddr, 32'h4);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap_pushpop_count", 32'(count), 32'd3);
    #1;
    chk("wrap_d2_addr", MemAddr, 32'h8);
    tick();
    chk("wrap_d3_addr", MemAddr, 32'hC);
    tick();
    chk("wrap_d4_addr", MemAddr, 32'h10);
    chk("wrap_d4_data", MemWriteData, 32'hD0000004);
    tick();
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_dm_d3", dm[3], 32'hD0000003);
    chk("wrap_dm_d4", dm[4], 32'hD0000004);

    // Reset while draining discards the remaining entries
    drain_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h40 + 32'(i * 4), 32'hE0000000 + 32'(i));
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drain_hold = 1'b0;
    #1;
    chk("rstd_first_addr", MemAddr, 32'h40);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rstd_memwrite", 32'(MemWrite), 32'd0);
    chk("rstd_count", 32'(count), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("rstd_dm0", dm[16], 32'hE0000000);
    chk("rstd_dm1", dm[17], 32'h0);
    chk("rstd_dm2", dm[18], 32'h0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
